btn_mode_router: RTL and testbench

- Parametrised front end that turns N raw push-buttons plus a mode switch bus into one-cycle function pulses for the music player and the wave display.
- Replaces the per-top switch-case remap and the bank of independent button press units with a single block.
- Per button: synchroniser, debounce, edge detect, and optional auto-repeat (hold-to-scan for ff/rewind).
- The mode→function map is a parameter. A mode change locks out all outputs until every button is released, so no ghost events occur.

---
 rtl/btn_router_pkg.sv | 28 ++
 rtl/btn_mode_router_debounce.sv | 48 ++++
 rtl/btn_mode_router.sv | 164 ++++++++++++++++
 tb/tb_btn_mode_router.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_router_pkg.sv
// Shared types, function indices and default maps for the button/mode front end.
// The default map mirrors the music player (mode 0) and wave display (mode 1).
package btn_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    localparam int F_PLAY   = 0;
    localparam int F_NEXT   = 1;
    localparam int F_FF     = 2;
    localparam int F_REWIND = 3;
    localparam int F_WD0    = 4;
    localparam int F_WD1    = 5;
    localparam int F_WD2    = 6;
    localparam int F_NONE   = 15;

    // Nibble (m*4+b): mode 0 = play/next/ff/rewind, mode 1 = wave display.
    localparam logic [63:0] DEFAULT_MODE_MAP    = 64'hFFFF_FFFF_F654_3210;
    localparam logic [7:0]  DEFAULT_REPEAT_MASK = 8'b0000_1100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_mode_router_debounce.sv
// One button: 2-FF synchroniser, saturating debounce counter, stable level
// and registered rise/fall strobes aligned with the stable change.
module btn_debounce #(
    parameter int DEBOUNCE_W = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic stable,
    output logic rise,
    output logic fall
);

    // Toggle on the cycle the counter would hit all-ones.
    localparam logic [DEBOUNCE_W-1:0] CNT_END =
        DEBOUNCE_W'((2 ** DEBOUNCE_W) - 2);

    logic                  meta;
    logic                  sync;
    logic [DEBOUNCE_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_END) begin
                cnt    <= '0;
                stable <= sync;
                rise   <= sync;
                fall   <= ~sync;
            end else begin
                cnt <= cnt + DEBOUNCE_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_mode_router.sv
// Buttons + mode switches to one-cycle function pulses and held levels,
// with auto-repeat and a lockout after every mode change.
module btn_mode_router
    import btn_router_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int MODE_W     = 2,
    parameter int NUM_FUNCS  = 8,
    parameter int FIDX_W     = 4,
    parameter logic [(2**MODE_W)*NUM_BTN*FIDX_W-1:0] MODE_MAP =
        DEFAULT_MODE_MAP,
    parameter logic [NUM_FUNCS-1:0] REPEAT_MASK = DEFAULT_REPEAT_MASK,
    parameter int DEBOUNCE_W    = 20,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_BTN-1:0]   btn,
    input  logic [MODE_W-1:0]    sw,
    output logic [NUM_FUNCS-1:0] func_pulse,
    output logic [NUM_FUNCS-1:0] func_level,
    output logic [MODE_W-1:0]    mode,
    output logic                 locked
);

    localparam int TMR_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] DELAY_END  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_END = TMR_W'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic [MODE_W-1:0]  sw_meta;
    logic [MODE_W-1:0]  sw_sync;
    logic               mode_chg;
    logic               hold;

    btn_state_t        state    [NUM_BTN];
    btn_state_t        state_nx [NUM_BTN];
    logic [TMR_W-1:0]  tmr      [NUM_BTN];
    logic [TMR_W-1:0]  tmr_nx   [NUM_BTN];
    logic [FIDX_W-1:0] fidx     [NUM_BTN];
    logic              rep      [NUM_BTN];
    logic              hit      [NUM_BTN];

    logic [NUM_FUNCS-1:0] pulse_nx;
    logic [NUM_FUNCS-1:0] level_nx;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_W(DEBOUNCE_W)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .btn    (btn[b]),
            .stable (stable[b]),
            .rise   (rise[b]),
            .fall   (fall[b])
        );
    end

    assign mode_chg = (sw_sync != mode);
    assign hold     = mode_chg | locked;

    always_comb begin
        for (int b = 0; b < NUM_BTN; b++) begin
            fidx[b] = MODE_MAP[(int'(mode) * NUM_BTN + b) * FIDX_W +: FIDX_W];
            rep[b]  = 1'b0;
            for (int f = 0; f < NUM_FUNCS; f++) begin
                if (fidx[b] == FIDX_W'(f)) rep[b] = REPEAT_MASK[f];
            end
        end
    end

    always_comb begin
        pulse_nx = '0;
        level_nx = '0;
        for (int b = 0; b < NUM_BTN; b++) begin
            state_nx[b] = state[b];
            tmr_nx[b]   = '0;
            hit[b]      = 1'b0;
            unique case (state[b])
                ST_IDLE: begin
                    if (rise[b]) begin
                        hit[b] = 1'b1;
                        if (rep[b]) state_nx[b] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fall[b]) begin
                        state_nx[b] = ST_IDLE;
                    end else if (tmr[b] == DELAY_END) begin
                        hit[b]      = 1'b1;
                        state_nx[b] = ST_REPEAT;
                    end else begin
                        tmr_nx[b] = tmr[b] + TMR_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (fall[b]) begin
                        state_nx[b] = ST_IDLE;
                    end else if (tmr[b] == PERIOD_END) begin
                        hit[b] = 1'b1;
                    end else begin
                        tmr_nx[b] = tmr[b] + TMR_W'(1);
                    end
                end
                default: state_nx[b] = ST_IDLE;
            endcase
            // A mode change outranks any press edge in the same cycle.
            if (hold) begin
                state_nx[b] = ST_IDLE;
                tmr_nx[b]   = '0;
                hit[b]      = 1'b0;
            end
            for (int f = 0; f < NUM_FUNCS; f++) begin
                if (!hold && fidx[b] == FIDX_W'(f)) begin
                    pulse_nx[f] = pulse_nx[f] | hit[b];
                    level_nx[f] = level_nx[f] | stable[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BTN; b++) begin
                state[b] <= ST_IDLE;
                tmr[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BTN; b++) begin
                state[b] <= state_nx[b];
                tmr[b]   <= tmr_nx[b];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            mode       <= '0;
            locked     <= 1'b0;
            func_pulse <= '0;
            func_level <= '0;
        end else begin
            sw_meta    <= sw;
            sw_sync    <= sw_meta;
            func_pulse <= pulse_nx;
            func_level <= level_nx;
            if (mode_chg) begin
                mode   <= sw_sync;
                locked <= 1'b1;
            end else if (locked && stable == '0) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_mode_router.sv
// Bench for btn_mode_router: directed scenarios plus random button/mode
// traffic, all compared cycle by cycle against a behavioural model.
module tb_btn_mode_router;
    import btn_router_pkg::*;

    localparam int NB = 4;
    localparam int MW = 2;
    localparam int NF = 8;
    localparam int FW = 4;
    localparam int DW = 2;
    localparam int RD = 10;
    localparam int RP = 4;
    localparam logic [63:0] MAP   = 64'h7032_6F11_9654_3201;
    localparam logic [7:0]  RMASK = 8'h0C;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NB-1:0] btn;
    logic [MW-1:0] sw;
    logic [NF-1:0] func_pulse;
    logic [NF-1:0] func_level;
    logic [MW-1:0] mode;
    logic          locked;

    btn_mode_router #(
        .NUM_BTN(NB), .MODE_W(MW), .NUM_FUNCS(NF), .FIDX_W(FW),
        .MODE_MAP(MAP), .REPEAT_MASK(RMASK), .DEBOUNCE_W(DW),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn(btn), .sw(sw),
        .func_pulse(func_pulse), .func_level(func_level),
        .mode(mode), .locked(locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // map_tab[mode][button] = function index
    int map_tab [4][4] = '{'{1, 0, 2, 3}, '{4, 5, 6, 9},
                           '{1, 1, 15, 6}, '{2, 3, 0, 7}};

    logic [2*NF+MW:0] obs;
    logic [2*NF+MW:0] want;
    assign obs = {func_pulse, func_level, mode, locked};

    bit            m_s1 [NB];
    bit            m_s2 [NB];
    bit            m_st [NB];
    bit            m_prev [NB];
    int            m_run [NB];
    int            m_age [NB];
    bit            m_live [NB];
    logic [MW-1:0] m_sw1, m_sw2, m_mode;
    bit            m_lock;

    function automatic bit rep_of(input int f);
        if (f >= NF) return 1'b0;
        return RMASK[f];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_st[b] = 0; m_prev[b] = 0;
            m_run[b] = 0; m_age[b] = 0; m_live[b] = 0;
        end
        m_sw1 = '0; m_sw2 = '0; m_mode = '0; m_lock = 0;
        want = '0;
    endtask

    // One clock of the reference: press edge pulses, then a pulse every
    // RP cycles once a repeatable hold has lasted RD cycles.
    task automatic model_step(input logic [NB-1:0] bi, input logic [MW-1:0] si);
        logic [NF-1:0] np;
        logic [NF-1:0] nl;
        bit chg, blk, free, rose, fell, hit;
        int f;
        np = '0; nl = '0;
        chg = (m_sw2 != m_mode);
        blk = chg || m_lock;
        free = 1;
        for (int b = 0; b < NB; b++) if (m_st[b]) free = 0;
        for (int b = 0; b < NB; b++) begin
            f = map_tab[m_mode][b];
            rose = m_st[b] && !m_prev[b];
            fell = !m_st[b] && m_prev[b];
            hit = 0;
            if (blk) begin
                m_live[b] = 0;
            end else if (rose) begin
                hit = 1;
                m_live[b] = rep_of(f);
                m_age[b] = 0;
            end else if (m_live[b]) begin
                if (fell) begin
                    m_live[b] = 0;
                end else begin
                    m_age[b]++;
                    hit = (m_age[b] >= RD) && ((m_age[b] - RD) % RP == 0);
                end
            end
            if (!blk && f < NF) begin
                if (hit) np[f] = 1'b1;
                if (m_st[b]) nl[f] = 1'b1;
            end
            m_prev[b] = m_st[b];
            if (m_s2[b] != m_st[b]) begin
                m_run[b]++;
                if (m_run[b] == (1 << DW) - 1) begin
                    m_st[b] = m_s2[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = bi[b];
        end
        if (chg) begin
            m_mode = m_sw2;
            m_lock = 1;
        end else if (m_lock && free) begin
            m_lock = 0;
        end
        m_sw2 = m_sw1;
        m_sw1 = si;
        want = {np, nl, m_mode, m_lock};
    endtask

    task automatic tick();
        logic [NB-1:0] bn;
        logic [MW-1:0] sn;
        bn = btn;
        sn = sw;
        @(posedge clk);
        model_step(bn, sn);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn = '0;
        sw = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_hold got=%h want=0", obs);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL reset_idle k=%0d got=%h want=%h", k, obs, want);
            end
        end
    endtask

    task automatic test_single_press();
        int n = 0;
        int at = -1;
        int hi = 0;
        btn[1] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 21) btn[1] = 1'b0;
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL single k=%0d got=%h want=%h", k, obs, want);
            end
            if (func_pulse[F_PLAY]) begin
                n++;
                if (at < 0) at = k;
            end
            if (func_level[F_PLAY]) hi++;
        end
        checks++;
        if (n !== 1 || at !== 6) begin
            failures++;
            $display("FAIL single_latency n=%0d at=%0d want n=1 at=6", n, at);
        end
        checks++;
        if (hi !== 20) begin
            failures++;
            $display("FAIL single_level cycles=%0d want=20", hi);
        end
    endtask

    task automatic test_bounce();
        int n = 0;
        int at = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k <= 20) btn[1] = (k % 2 == 1);
            else if (k <= 40) btn[1] = 1'b1;
            else btn[1] = 1'b0;
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL bounce k=%0d got=%h want=%h", k, obs, want);
            end
            if (func_pulse[F_PLAY]) begin
                n++;
                if (at < 0) at = k;
            end
        end
        checks++;
        if (n !== 1 || at !== 26) begin
            failures++;
            $display("FAIL bounce_once n=%0d at=%0d want n=1 at=26", n, at);
        end
    endtask

    task automatic test_repeat();
        int got [$];
        int exp_t [6] = '{6, 16, 20, 24, 28, 32};
        btn[2] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k == 31) btn[2] = 1'b0;
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL repeat k=%0d got=%h want=%h", k, obs, want);
            end
            if (func_pulse[F_FF]) got.push_back(k);
        end
        checks++;
        if (got.size() !== 6) begin
            failures++;
            $display("FAIL repeat_count got=%0d want=6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== exp_t[i]) begin
                    failures++;
                    $display("FAIL repeat_time i=%0d got=%0d want=%0d",
                             i, got[i], exp_t[i]);
                end
            end
        end
    endtask

    task automatic test_mode_lock();
        int quiet = 0;
        int n = 0;
        int at = -1;
        btn[2] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) sw = 2'd1;
            if (k == 15) sw = 2'd3;
            if (k == 20) sw = 2'd1;
            if (k == 30) btn[2] = 1'b0;
            if (k == 40) btn[2] = 1'b1;
            if (k == 50) btn[2] = 1'b0;
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL lock k=%0d got=%h want=%h", k, obs, want);
            end
            if (k >= 11 && k <= 39 && func_pulse != '0) quiet++;
            if (k >= 40 && func_pulse[F_WD2]) begin
                n++;
                if (at < 0) at = k;
            end
            if (k == 12 || k == 17 || k == 22) begin
                checks++;
                if (locked !== 1'b1 || mode !== ((k == 17) ? 2'd3 : 2'd1)) begin
                    failures++;
                    $display("FAIL lock_mode k=%0d mode=%0d locked=%0b", k, mode, locked);
                end
            end
            if (k == 34 || k == 35) begin
                checks++;
                if (locked !== (k == 34)) begin
                    failures++;
                    $display("FAIL lock_clear k=%0d locked=%0b", k, locked);
                end
            end
        end
        checks++;
        if (quiet !== 0) begin
            failures++;
            $display("FAIL lock_quiet pulses=%0d want=0", quiet);
        end
        checks++;
        if (n !== 1 || at !== 45) begin
            failures++;
            $display("FAIL lock_after n=%0d at=%0d want n=1 at=45", n, at);
        end
    endtask

    task automatic test_merge();
        int n = 0;
        int at = -1;
        int other = 0;
        for (int k = 1; k <= 35; k++) begin
            if (k == 1) sw = 2'd2;
            if (k == 6) btn[2:0] = 3'b111;
            if (k == 20) btn[2:0] = 3'b000;
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL merge k=%0d got=%h want=%h", k, obs, want);
            end
            if (func_pulse[F_NEXT]) begin
                n++;
                if (at < 0) at = k;
            end
            if ((func_pulse & ~8'h02) != '0) other++;
            if (k == 15) begin
                checks++;
                if (func_level !== 8'h02) begin
                    failures++;
                    $display("FAIL merge_level got=%h want=02", func_level);
                end
            end
        end
        checks++;
        if (n !== 1 || at !== 11 || other !== 0) begin
            failures++;
            $display("FAIL merge_once n=%0d at=%0d other=%0d want 1/11/0", n, at, other);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) btn[3] = 1'b1;
            if (k == 8) sw = 2'd0;
            if (k == 20) btn[3] = 1'b0;
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL simul k=%0d got=%h want=%h", k, obs, want);
            end
            if (func_pulse != '0) n++;
            if (k == 10 || k == 25) begin
                checks++;
                if (locked !== (k == 10) || mode !== 2'd0) begin
                    failures++;
                    $display("FAIL simul_lock k=%0d locked=%0b mode=%0d", k, locked, mode);
                end
            end
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL simul_quiet pulses=%0d want=0", n);
        end
    endtask

    task automatic test_random();
        int left [NB];
        for (int b = 0; b < NB; b++) left[b] = $urandom_range(1, 30);
        for (int k = 1; k <= 800; k++) begin
            for (int b = 0; b < NB; b++) begin
                left[b]--;
                if (left[b] <= 0) begin
                    btn[b] = ~btn[b];
                    left[b] = $urandom_range(1, 30);
                end
            end
            if ($urandom_range(0, 99) == 0) sw = MW'($urandom_range(0, 3));
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL random k=%0d got=%h want=%h", k, obs, want);
            end
        end
        btn = '0;
        sw = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL settle k=%0d got=%h want=%h", k, obs, want);
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        int at = -1;
        btn[2] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL pre_reset k=%0d got=%h want=%h", k, obs, want);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL async_clear got=%h want=0", obs);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL async_hold got=%h want=0", obs);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 11) btn[2] = 1'b0;
            tick();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL post_reset k=%0d got=%h want=%h", k, obs, want);
            end
            if (func_pulse[F_FF]) begin
                n++;
                if (at < 0) at = k;
            end
        end
        checks++;
        if (n !== 1 || at !== 6) begin
            failures++;
            $display("FAIL reset_press n=%0d at=%0d want n=1 at=6", n, at);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_mode_lock();
        test_merge();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
